// File: rtl/env_grid_decay.sv
// -----------------------------------------------------------------------------
// env_grid_decay
//   Environment grid for the ant simulation. Each cell holds a pheromone signal
//   (SIGNAL_BITS) and a sugar bit. The ant update engines write through NUM_WR
//   independent channels and read through the lookup port. The VGA renderer
//   reads through the render port. A periodic sweeper evaporates the signal one
//   row per cycle.
//
// Ports:
//   newLocClock             simulation clock
//   RESET_SIM_N             asynchronous active-low reset, clears every cell
//   decay_en                enables the evaporation timer
//   wr_flag/wr_add/wr_sugar per-channel strobe, add-mode select, sugar data
//   wr_X/wr_Y/wr_signal     packed per-channel column/row/signal, ch0 in LSBs
//   lookup_X/lookup_Y       lookup coordinates -> lookup_signal/lookup_sugar
//   render_X/render_Y       render coordinates -> render_signal/render_sugar
//   decay_busy              high while a sweep is running
//   sweep_done              one-cycle pulse after the last row has decayed
//   sugar_count             number of cells with sugar set (ENV_SUGAR_COUNT_EN)
//
// Optional feature macro: ENV_SUGAR_COUNT_EN adds the sugar_count output.
// -----------------------------------------------------------------------------
module env_grid_decay #(
   parameter int unsigned PIXELS_X     = 64,
   parameter int unsigned PIXELS_Y     = 48,
   parameter int unsigned X_BITS       = 6,
   parameter int unsigned Y_BITS       = 6,
   parameter int unsigned SIGNAL_BITS  = 4,
   parameter int unsigned NUM_WR       = 2,
   parameter int unsigned DECAY_PERIOD = 1024,
   parameter int unsigned DECAY_STEP   = 1
) (
   input  logic                          newLocClock,
   input  logic                          RESET_SIM_N,
   input  logic                          decay_en,
   input  logic [NUM_WR-1:0]             wr_flag,
   input  logic [NUM_WR-1:0]             wr_add,
   input  logic [NUM_WR*X_BITS-1:0]      wr_X,
   input  logic [NUM_WR*Y_BITS-1:0]      wr_Y,
   input  logic [NUM_WR*SIGNAL_BITS-1:0] wr_signal,
   input  logic [NUM_WR-1:0]             wr_sugar,
   input  logic [X_BITS-1:0]             lookup_X,
   input  logic [Y_BITS-1:0]             lookup_Y,
   output logic [SIGNAL_BITS-1:0]        lookup_signal,
   output logic                          lookup_sugar,
   input  logic [X_BITS-1:0]             render_X,
   input  logic [Y_BITS-1:0]             render_Y,
   output logic [SIGNAL_BITS-1:0]        render_signal,
   output logic                          render_sugar,
   output logic                          decay_busy,
`ifdef ENV_SUGAR_COUNT_EN
   output logic [X_BITS+Y_BITS:0]        sugar_count,
`endif
   output logic                          sweep_done
);

   localparam int unsigned TIMER_W = (DECAY_PERIOD > 1) ? $clog2(DECAY_PERIOD) : 1;
   localparam logic [SIGNAL_BITS-1:0] STEP = SIGNAL_BITS'(DECAY_STEP);
   localparam logic [TIMER_W-1:0]     TIMER_LAST = TIMER_W'(DECAY_PERIOD - 1);
   localparam logic [Y_BITS-1:0]      ROW_LAST = Y_BITS'(PIXELS_Y - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SWEEP,
      ST_DONE
   } state_t;

   // Cell storage
   logic [SIGNAL_BITS-1:0] cell_sig [PIXELS_Y][PIXELS_X];
   logic                   cell_sug [PIXELS_Y][PIXELS_X];

   // Sweeper state
   state_t               state;
   logic [TIMER_W-1:0]   timer;
   logic [Y_BITS-1:0]    row;

   // Per-channel decoded write request
   logic [X_BITS-1:0]      ch_x       [NUM_WR];
   logic [Y_BITS-1:0]      ch_y       [NUM_WR];
   logic [SIGNAL_BITS-1:0] ch_wsig    [NUM_WR];
   logic [SIGNAL_BITS-1:0] ch_old_sig [NUM_WR];
   logic [SIGNAL_BITS:0]   ch_sum     [NUM_WR];
   logic [SIGNAL_BITS-1:0] ch_new_sig [NUM_WR];
   logic [NUM_WR-1:0]      ch_valid;
   logic [NUM_WR-1:0]      win;

   // ---------------------------------------------------------------------------
   // Read ports
   // ---------------------------------------------------------------------------
   logic lookup_in, render_in;

   assign lookup_in = (32'(lookup_X) < PIXELS_X) && (32'(lookup_Y) < PIXELS_Y);
   assign render_in = (32'(render_X) < PIXELS_X) && (32'(render_Y) < PIXELS_Y);

   assign lookup_signal = lookup_in ? cell_sig[lookup_Y][lookup_X] : '0;
   assign lookup_sugar  = lookup_in ? cell_sug[lookup_Y][lookup_X] : 1'b0;
   assign render_signal = render_in ? cell_sig[render_Y][render_X] : '0;
   assign render_sugar  = render_in ? cell_sug[render_Y][render_X] : 1'b0;

   // ---------------------------------------------------------------------------
   // Write channel decode: unpack, range check, next value per channel.
   // Add mode reads the stored (pre-decay) value of the target cell.
   // ---------------------------------------------------------------------------
   for (genvar gc = 0; gc < NUM_WR; gc++) begin : g_ch
      assign ch_x[gc]    = wr_X[gc*X_BITS +: X_BITS];
      assign ch_y[gc]    = wr_Y[gc*Y_BITS +: Y_BITS];
      assign ch_wsig[gc] = wr_signal[gc*SIGNAL_BITS +: SIGNAL_BITS];

      assign ch_valid[gc] = wr_flag[gc]
                          && (32'(ch_x[gc]) < PIXELS_X)
                          && (32'(ch_y[gc]) < PIXELS_Y);

      assign ch_old_sig[gc] = ch_valid[gc] ? cell_sig[ch_y[gc]][ch_x[gc]] : '0;
      assign ch_sum[gc]     = {1'b0, ch_old_sig[gc]} + {1'b0, ch_wsig[gc]};
      assign ch_new_sig[gc] = !wr_add[gc]          ? ch_wsig[gc] :
                              ch_sum[gc][SIGNAL_BITS] ? '1 :
                              ch_sum[gc][SIGNAL_BITS-1:0];
   end

   // A channel wins unless a lower-index valid channel targets the same cell.
   // After this, winning channels always address distinct cells.
   always_comb begin
      win = ch_valid;
      for (int unsigned c = 1; c < NUM_WR; c++) begin
         for (int unsigned j = 0; j < c; j++) begin
            if (ch_valid[j] && (ch_x[j] == ch_x[c]) && (ch_y[j] == ch_y[c])) begin
               win[c] = 1'b0;
            end
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Cells. A winning write overrides the sweeper on the same cell, so that
   // cell skips decay for this sweep.
   // ---------------------------------------------------------------------------
   for (genvar gy = 0; gy < PIXELS_Y; gy++) begin : g_row
      for (genvar gx = 0; gx < PIXELS_X; gx++) begin : g_col
         always_ff @(posedge newLocClock or negedge RESET_SIM_N) begin
            if (!RESET_SIM_N) begin
               cell_sig[gy][gx] <= '0;
               cell_sug[gy][gx] <= 1'b0;
            end else begin
               if ((state == ST_SWEEP) && (row == Y_BITS'(gy))) begin
                  cell_sig[gy][gx] <= (cell_sig[gy][gx] > STEP) ?
                                      (cell_sig[gy][gx] - STEP) : '0;
               end
               for (int unsigned c = 0; c < NUM_WR; c++) begin
                  if (win[c] && (ch_x[c] == X_BITS'(gx)) && (ch_y[c] == Y_BITS'(gy))) begin
                     cell_sig[gy][gx] <= ch_new_sig[c];
                     cell_sug[gy][gx] <= wr_sugar[c];
                  end
               end
            end
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Evaporation sweeper
   // ---------------------------------------------------------------------------
   always_ff @(posedge newLocClock or negedge RESET_SIM_N) begin
      if (!RESET_SIM_N) begin
         state      <= ST_IDLE;
         timer      <= '0;
         row        <= '0;
         decay_busy <= 1'b0;
         sweep_done <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               sweep_done <= 1'b0;
               if (decay_en) begin
                  if (timer == TIMER_LAST) begin
                     timer      <= '0;
                     row        <= '0;
                     decay_busy <= 1'b1;
                     state      <= ST_SWEEP;
                  end else begin
                     timer <= timer + 1'b1;
                  end
               end
            end
            ST_SWEEP: begin
               timer <= '0;
               if (row == ROW_LAST) begin
                  row        <= '0;
                  decay_busy <= 1'b0;
                  sweep_done <= 1'b1;
                  state      <= ST_DONE;
               end else begin
                  row <= row + 1'b1;
               end
            end
            ST_DONE: begin
               sweep_done <= 1'b0;
               state      <= ST_IDLE;
            end
            default: begin
               decay_busy <= 1'b0;
               sweep_done <= 1'b0;
               state      <= ST_IDLE;
            end
         endcase
      end
   end

`ifdef ENV_SUGAR_COUNT_EN
   // ---------------------------------------------------------------------------
   // Sugar population count, updated from the winning writes only so that a
   // cell hit by several channels in one cycle is counted once.
   // ---------------------------------------------------------------------------
   localparam int unsigned CNT_W = X_BITS + Y_BITS + 1;

   logic             ch_old_sug [NUM_WR];
   logic [CNT_W-1:0] cnt_inc;
   logic [CNT_W-1:0] cnt_dec;

   for (genvar gc = 0; gc < NUM_WR; gc++) begin : g_sug
      assign ch_old_sug[gc] = ch_valid[gc] ? cell_sug[ch_y[gc]][ch_x[gc]] : 1'b0;
   end

   always_comb begin
      cnt_inc = '0;
      cnt_dec = '0;
      for (int unsigned c = 0; c < NUM_WR; c++) begin
         if (win[c] && !ch_old_sug[c] && wr_sugar[c]) begin
            cnt_inc = cnt_inc + CNT_W'(1);
         end
         if (win[c] && ch_old_sug[c] && !wr_sugar[c]) begin
            cnt_dec = cnt_dec + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge newLocClock or negedge RESET_SIM_N) begin
      if (!RESET_SIM_N) begin
         sugar_count <= '0;
      end else begin
         sugar_count <= sugar_count + cnt_inc - cnt_dec;
      end
   end
`endif

endmodule

// File: tb/tb_env_grid_decay.sv
// -----------------------------------------------------------------------------
// tb_env_grid_decay
//   Directed bench for env_grid_decay with DECAY_PERIOD=8, DECAY_STEP=1 and the
//   default 64x48 grid. Expected values are hand computed.
// -----------------------------------------------------------------------------
module tb_env_grid_decay;

   localparam int unsigned XB = 6;
   localparam int unsigned YB = 6;
   localparam int unsigned SB = 4;
   localparam int unsigned NW = 2;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              decay_en = 1'b0;
   logic [NW-1:0]     wr_flag = '0;
   logic [NW-1:0]     wr_add = '0;
   logic [NW*XB-1:0]  wr_X = '0;
   logic [NW*YB-1:0]  wr_Y = '0;
   logic [NW*SB-1:0]  wr_signal = '0;
   logic [NW-1:0]     wr_sugar = '0;
   logic [XB-1:0]     lookup_X = '0;
   logic [YB-1:0]     lookup_Y = '0;
   logic [SB-1:0]     lookup_signal;
   logic              lookup_sugar;
   logic [XB-1:0]     render_X = '0;
   logic [YB-1:0]     render_Y = '0;
   logic [SB-1:0]     render_signal;
   logic              render_sugar;
   logic              decay_busy;
   logic              sweep_done;
`ifdef ENV_SUGAR_COUNT_EN
   logic [XB+YB:0]    sugar_count;
`endif

   int n_checks = 0;
   int n_errors = 0;

   env_grid_decay #(
      .PIXELS_X     (64),
      .PIXELS_Y     (48),
      .X_BITS       (XB),
      .Y_BITS       (YB),
      .SIGNAL_BITS  (SB),
      .NUM_WR       (NW),
      .DECAY_PERIOD (8),
      .DECAY_STEP   (1)
   ) dut (
      .newLocClock   (clk),
      .RESET_SIM_N   (rst_n),
      .decay_en      (decay_en),
      .wr_flag       (wr_flag),
      .wr_add        (wr_add),
      .wr_X          (wr_X),
      .wr_Y          (wr_Y),
      .wr_signal     (wr_signal),
      .wr_sugar      (wr_sugar),
      .lookup_X      (lookup_X),
      .lookup_Y      (lookup_Y),
      .lookup_signal (lookup_signal),
      .lookup_sugar  (lookup_sugar),
      .render_X      (render_X),
      .render_Y      (render_Y),
      .render_signal (render_signal),
      .render_sugar  (render_sugar),
      .decay_busy    (decay_busy),
`ifdef ENV_SUGAR_COUNT_EN
      .sugar_count   (sugar_count),
`endif
      .sweep_done    (sweep_done)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int got, input int exp);
      n_checks++;
      if (got != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_wr(input int ch, input int x, input int y, input int s,
                         input bit sug, input bit add);
      wr_flag[ch]              = 1'b1;
      wr_add[ch]               = add;
      wr_X[ch*XB +: XB]        = XB'(x);
      wr_Y[ch*YB +: YB]        = YB'(y);
      wr_signal[ch*SB +: SB]   = SB'(s);
      wr_sugar[ch]             = sug;
   endtask

   task automatic clr_wr();
      wr_flag   = '0;
      wr_add    = '0;
      wr_X      = '0;
      wr_Y      = '0;
      wr_signal = '0;
      wr_sugar  = '0;
   endtask

   // Reads one cell through the lookup port; consumes 1 ns.
   task automatic chk_cell(input string tag, input int x, input int y,
                           input int esig, input int esug);
      lookup_X = XB'(x);
      lookup_Y = YB'(y);
      #1;
      check({tag, ".sig"}, int'(lookup_signal), esig);
      check({tag, ".sug"}, int'(lookup_sugar), esug);
   endtask

   initial begin
      int  cnt;
      bit  busy_seen;

      // ---- reset state ----
      #12;
      check("rst_busy", int'(decay_busy), 0);
      check("rst_done", int'(sweep_done), 0);
      chk_cell("rst_cell", 3, 5, 0, 0);
      rst_n = 1'b1;
      tick();

      // ---- channel 0 overwrite, visible the cycle after the strobe ----
      set_wr(0, 3, 5, 9, 1'b1, 1'b0);
      #1;
      check("ow_before_edge", int'(lookup_signal), 0);
      tick();
      clr_wr();
      chk_cell("ow_lookup", 3, 5, 9, 1);
      render_X = 6'd3;
      render_Y = 6'd5;
      #1;
      check("ow_render.sig", int'(render_signal), 9);
      check("ow_render.sug", int'(render_sugar), 1);

      // ---- add mode with saturation ----
      set_wr(0, 20, 7, 12, 1'b0, 1'b0);
      set_wr(1, 21, 7, 5, 1'b0, 1'b0);
      tick();
      clr_wr();
      set_wr(1, 20, 7, 7, 1'b1, 1'b1);
      tick();
      clr_wr();
      chk_cell("add_sat", 20, 7, 15, 1);
      set_wr(1, 21, 7, 2, 1'b0, 1'b1);
      tick();
      clr_wr();
      chk_cell("add_plain", 21, 7, 7, 0);

      // ---- same-cell conflict: lowest channel wins ----
      set_wr(0, 10, 10, 4, 1'b0, 1'b0);
      set_wr(1, 10, 10, 11, 1'b1, 1'b0);
      tick();
      clr_wr();
      chk_cell("conflict", 10, 10, 4, 0);
      set_wr(0, 12, 12, 2, 1'b0, 1'b0);
      set_wr(1, 13, 12, 8, 1'b1, 1'b0);
      tick();
      clr_wr();
      chk_cell("dual_ch0", 12, 12, 2, 0);
      chk_cell("dual_ch1", 13, 12, 8, 1);

      // ---- out-of-range write ignored, out-of-range read gives 0 ----
      set_wr(0, 0, 50, 5, 1'b1, 1'b0);
      tick();
      clr_wr();
      chk_cell("oor_read", 0, 50, 0, 0);
      chk_cell("oor_alias", 0, 2, 0, 0);

      // ---- decay setup ----
      set_wr(0, 1, 0, 3, 1'b0, 1'b0);
      set_wr(1, 2, 47, 1, 1'b0, 1'b0);
      tick();
      set_wr(0, 5, 1, 3, 1'b1, 1'b0);
      set_wr(1, 7, 10, 9, 1'b0, 1'b0);
      tick();
      clr_wr();
      set_wr(0, 8, 11, 9, 1'b0, 1'b0);
      tick();
      clr_wr();
      check("idle_busy", int'(decay_busy), 0);

      // ---- first sweep: starts after 8 enabled cycles ----
      decay_en = 1'b1;
      repeat (7) tick();
      check("busy_before_period", int'(decay_busy), 0);
      tick();
      check("busy_at_period", int'(decay_busy), 1);
      cnt = 0;
      while (decay_busy === 1'b1 && cnt < 200) begin
         tick();
         cnt++;
      end
      check("sweep1_len", cnt, 48);
      check("sweep1_done", int'(sweep_done), 1);
      chk_cell("sw1_a", 1, 0, 2, 0);
      chk_cell("sw1_b", 2, 47, 0, 0);
      chk_cell("sw1_sugar", 5, 1, 2, 1);
      chk_cell("sw1_c", 7, 10, 8, 0);
      tick();
      check("done_pulse_once", int'(sweep_done), 0);

      // ---- second sweep spacing: 57 cycles start to start ----
      cnt = 0;
      while (decay_busy !== 1'b1 && cnt < 100) begin
         tick();
         cnt++;
      end
      check("sweep2_gap", cnt, 8);

      // ---- writes racing the sweeper on rows 10 and 11 ----
      repeat (10) tick();
      set_wr(0, 7, 10, 6, 1'b0, 1'b0);
      tick();
      clr_wr();
      set_wr(0, 8, 11, 2, 1'b0, 1'b1);
      tick();
      clr_wr();
      decay_en = 1'b0;
      cnt = 0;
      while (sweep_done !== 1'b1 && cnt < 100) begin
         tick();
         cnt++;
      end
      check("sweep2_done", int'(sweep_done), 1);
      chk_cell("sw2_a", 1, 0, 1, 0);
      chk_cell("sw2_b", 2, 47, 0, 0);
      chk_cell("sw2_wr_ow", 7, 10, 6, 0);
      chk_cell("sw2_wr_add", 8, 11, 10, 0);

      // ---- decay_en low: no further sweep ----
      busy_seen = 1'b0;
      repeat (80) begin
         tick();
         if (decay_busy !== 1'b0) busy_seen = 1'b1;
      end
      check("no_restart", int'(busy_seen), 0);
      chk_cell("sw2_sugar", 5, 1, 1, 1);

      // ---- asynchronous reset with grid populated ----
      chk_cell("pre_rst", 3, 5, 7, 1);
      #1;
      rst_n = 1'b0;
      #1;
      check("async_rst.sig", int'(lookup_signal), 0);
      check("async_rst.sug", int'(lookup_sugar), 0);
      render_X = 6'd8;
      render_Y = 6'd11;
      #1;
      check("async_rst.render", int'(render_signal), 0);
      check("async_rst.busy", int'(decay_busy), 0);
      tick();
      rst_n = 1'b1;
      tick();

`ifdef ENV_SUGAR_COUNT_EN
      // ---- sugar population count ----
      check("cnt_rst", int'(sugar_count), 0);
      set_wr(0, 0, 0, 1, 1'b1, 1'b0);
      set_wr(1, 1, 0, 1, 1'b1, 1'b0);
      tick();
      clr_wr();
      check("cnt_two", int'(sugar_count), 2);
      set_wr(0, 2, 0, 1, 1'b1, 1'b0);
      set_wr(1, 2, 0, 1, 1'b1, 1'b0);
      tick();
      clr_wr();
      check("cnt_same_cell", int'(sugar_count), 3);
      set_wr(0, 1, 0, 0, 1'b0, 1'b0);
      set_wr(1, 0, 0, 3, 1'b1, 1'b0);
      tick();
      clr_wr();
      check("cnt_clear_one", int'(sugar_count), 2);
      set_wr(0, 5, 60, 0, 1'b1, 1'b0);
      tick();
      clr_wr();
      check("cnt_oor", int'(sugar_count), 2);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete, expected completion");
      $fatal(1);
   end

endmodule
